cas_byte_feeder: RTL and testbench

Upstream playback sequencer for the cassette square-wave generator. Buffers tape-image bytes written by the loader in a small FIFO. Prepends a configurable leader of sync bytes. Hands bytes one at a time to the square-wave generator through its `start`/`din`/`done` handshake, so the emulated machine hears an unbroken byte stream while `play` is held.

---
 rtl/cas_byte_feeder.sv | 163 ++++++++++++++++
 tb/tb_cas_byte_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_byte_feeder.sv
// Cassette playback feeder: FIFO-buffered tape bytes, sync leader, and
// start/done handshake toward the square-wave generator.
module cas_byte_feeder #(
    parameter int          DEPTH_LOG2  = 4,
    parameter int          LEADER_LEN  = 128,
    parameter logic [7:0]  LEADER_BYTE = 8'h55
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       play,
    input  logic       flush,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       sq_done,
    output logic       sq_start,
    output logic [7:0] sq_din,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = (LEADER_LEN > 0) ? $clog2(LEADER_LEN + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI
    } state_t;

    state_t                r_state;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [LW-1:0]         r_lead_cnt;
    logic                  r_src_lead;
    logic                  r_sq_start;
    logic [7:0]            r_sq_din;
    logic                  r_busy;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;

    logic                  w_lead_left;
    logic                  w_go;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_lead_left = (r_lead_cnt != '0);
    assign w_go        = play && (w_lead_left || !r_empty);
    // Source is latched on entry to ISSUE; pop/decrement happen as ISSUE ends.
    assign w_pop       = (r_state == S_ISSUE) && !r_src_lead && (r_count != '0);
    assign w_push      = wr && !flush && (!r_full || w_pop);
    assign w_ovf       = wr && !flush && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (flush)
            w_count_nxt = '0;
        else if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (DEPTH_LOG2+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (flush) begin
                r_rptr     <= '0;
                r_wptr     <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop)
                    r_rptr <= r_rptr + 1'b1;
                if (w_ovf)
                    r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_lead_cnt <= LW'(LEADER_LEN);
        else if (flush)
            r_lead_cnt <= LW'(LEADER_LEN);
        else if (r_state == S_ISSUE && r_src_lead && w_lead_left)
            r_lead_cnt <= r_lead_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sq_start <= 1'b0;
            r_sq_din   <= 8'h00;
            r_busy     <= 1'b0;
            r_src_lead <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state    <= S_ISSUE;
                        r_sq_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_src_lead <= w_lead_left;
                        r_sq_din   <= w_lead_left ? LEADER_BYTE : r_mem[r_rptr];
                    end
                end
                S_ISSUE: begin
                    r_sq_start <= 1'b0;
                    r_state    <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!sq_done)
                        r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (sq_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (w_go) begin
                            r_state    <= S_ISSUE;
                            r_sq_start <= 1'b1;
                            r_busy     <= 1'b1;
                            r_src_lead <= w_lead_left;
                            r_sq_din   <= w_lead_left ? LEADER_BYTE : r_mem[r_rptr];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sq_start = r_sq_start;
    assign sq_din   = r_sq_din;
    assign busy     = r_busy;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_cas_byte_feeder.sv
// Bench for cas_byte_feeder: flag vector table plus playback sequences
// against a behavioural square-generator model.
module tb_cas_byte_feeder;

    localparam int GEN_LAT = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       play = 1'b0;
    logic       flush = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       sq_done;
    logic       sq_start;
    logic [7:0] sq_din;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] issued [$];
    int         g_cnt;
    logic       prev_start;

    cas_byte_feeder #(
        .DEPTH_LOG2 (4),
        .LEADER_LEN (3),
        .LEADER_BYTE(8'h55)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .play    (play),
        .flush   (flush),
        .wr      (wr),
        .wr_data (wr_data),
        .sq_done (sq_done),
        .sq_start(sq_start),
        .sq_din  (sq_din),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Square generator: done drops on start, rises GEN_LAT cycles later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_cnt   <= 0;
            sq_done <= 1'b1;
        end else if (sq_start) begin
            g_cnt   <= GEN_LAT;
            sq_done <= 1'b0;
        end else if (g_cnt != 0) begin
            g_cnt <= g_cnt - 1;
            if (g_cnt == 1)
                sq_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_start <= 1'b0;
        end else begin
            if (sq_start) begin
                issued.push_back(sq_din);
                checks++;
                if (!(sq_done === 1'b1 && g_cnt == 0 && busy === 1'b1 && !prev_start)) begin
                    errors++;
                    $display("FAIL start_legal: done=%b gcnt=%0d busy=%b prev=%b",
                             sq_done, g_cnt, busy, prev_start);
                end
            end
            prev_start <= sq_start;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        @(negedge clk);
        wr      = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr      = 1'b0;
    endtask

    task automatic wait_issued(input int n, input string name);
        int k;
        k = 0;
        while (issued.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (issued.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d issues expected %0d", name, issued.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, {7'd0, busy}, 8'h00);
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       f;
        logic       e;
        logic       fu;
        logic       o;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        vecs[0] = '{w: 1'b1, d: 8'hA1, f: 1'b0, e: 1'b0, fu: 1'b0, o: 1'b0};
        vecs[1] = '{w: 1'b1, d: 8'h77, f: 1'b1, e: 1'b1, fu: 1'b0, o: 1'b0};
        vecs[2] = '{w: 1'b0, d: 8'h00, f: 1'b0, e: 1'b1, fu: 1'b0, o: 1'b0};
        vecs[3] = '{w: 1'b1, d: 8'h5A, f: 1'b0, e: 1'b0, fu: 1'b0, o: 1'b0};
        vecs[4] = '{w: 1'b0, d: 8'h00, f: 1'b1, e: 1'b1, fu: 1'b0, o: 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_start", {7'd0, sq_start}, 8'h00);
        chk("rst_din", sq_din, 8'h00);
        chk("rst_flags", {4'd0, busy, overflow, empty, full}, 8'b0000_0010);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            wr      = vecs[i].w;
            wr_data = vecs[i].d;
            flush   = vecs[i].f;
            @(posedge clk);
            #1;
            wr    = 1'b0;
            flush = 1'b0;
            chk($sformatf("vec%0d_flags", i), {5'd0, empty, full, overflow},
                {5'd0, vecs[i].e, vecs[i].fu, vecs[i].o});
        end

        // Leader only
        play = 1'b1;
        wait_issued(3, "leader_cnt");
        wait_idle("leader_idle");
        repeat (20) @(negedge clk);
        chk("leader_only3", 8'(issued.size()), 8'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("leader%0d", i), issued[i], 8'h55);

        // Data in order
        wr_byte(8'hA1);
        wr_byte(8'hB2);
        wr_byte(8'hC3);
        wait_issued(6, "data_cnt");
        wait_idle("data_idle");
        chk("data0", issued[3], 8'hA1);
        chk("data1", issued[4], 8'hB2);
        chk("data2", issued[5], 8'hC3);
        chk("data_empty", {7'd0, empty}, 8'h01);

        // Fill, overflow, flush
        play = 1'b0;
        for (int i = 0; i < 16; i++)
            wr_byte(8'(8'h10 + i));
        chk("fill_full", {6'd0, full, overflow}, 8'b10);
        wr_byte(8'hFF);
        chk("ovf_set", {6'd0, full, overflow}, 8'b11);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_flags", {5'd0, empty, full, overflow}, 8'b100);

        // Leader re-armed, then play dropped mid-byte
        base = issued.size();
        wr_byte(8'hD0);
        wr_byte(8'hD1);
        wr_byte(8'hD2);
        play = 1'b1;
        wait_issued(base + 4, "rearm_cnt");
        for (int i = 0; i < 3; i++)
            chk($sformatf("rearm%0d", i), issued[base+i], 8'h55);
        chk("rearm_d0", issued[base+3], 8'hD0);
        @(negedge clk);
        play = 1'b0;
        repeat (25) @(negedge clk);
        chk("pause_nostart", 8'(issued.size() - base), 8'd4);
        chk("pause_busy", {7'd0, busy}, 8'h00);
        play = 1'b1;
        wait_issued(base + 6, "resume_cnt");
        wait_idle("resume_idle");
        chk("resume_d1", issued[base+4], 8'hD1);
        chk("resume_d2", issued[base+5], 8'hD2);

        // Write while full alongside the ISSUE pop
        play = 1'b0;
        base = issued.size();
        for (int i = 0; i < 16; i++)
            wr_byte(8'(8'h20 + i));
        chk("sim_full0", {7'd0, full}, 8'h01);
        play = 1'b1;
        for (int k = 0; k < 50 && sq_start !== 1'b1; k++)
            @(negedge clk);
        chk("sim_seen_start", {7'd0, sq_start}, 8'h01);
        wr      = 1'b1;
        wr_data = 8'h99;
        @(posedge clk);
        #1;
        wr = 1'b0;
        chk("sim_full1", {6'd0, full, overflow}, 8'b10);
        wait_issued(base + 17, "sim_cnt");
        wait_idle("sim_idle");
        for (int i = 0; i < 16; i++)
            chk($sformatf("sim_d%0d", i), issued[base+i], 8'(8'h20 + i));
        chk("sim_last", issued[base+16], 8'h99);
        chk("sim_empty", {7'd0, empty}, 8'h01);
        for (int i = 0; i < issued.size(); i++)
            if (issued[i] == 8'hFF)
                chk("ff_never", issued[i], 8'h00);

        // Async reset mid-byte
        base = issued.size();
        wr_byte(8'h44);
        wait_issued(base + 1, "rst_issue");
        chk("rst_pre_busy", {7'd0, busy}, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_start", {7'd0, sq_start}, 8'h00);
        chk("arst_din", sq_din, 8'h00);
        chk("arst_flags", {4'd0, busy, overflow, empty, full}, 8'b0000_0010);
        play = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        base = issued.size();
        play = 1'b1;
        wait_issued(base + 3, "replay_cnt");
        wait_idle("replay_idle");
        for (int i = 0; i < 3; i++)
            chk($sformatf("replay%0d", i), issued[base+i], 8'h55);
        chk("replay_only3", 8'(issued.size() - base), 8'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
